// File: rtl/m9_flush_scheduler.sv
// M9 tile line-buffer arbiter: passes blender RMW traffic through while idle and,
// on frame_ready, drains every entry to SD_RAM as RGB565 with waitrequest handshake.
module m9_flush_scheduler #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DEPTH  = 128
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              blend_read,
  input  logic              blend_write,
  input  logic [ADDR_W-1:0] blend_addr,
  input  logic [23:0]       blend_wdata,
  output logic [23:0]       blend_rdata,
  output logic              blend_stall,
  input  logic              frame_ready,
  input  logic [31:0]       frame_base,
  output logic [ADDR_W-1:0] m9_raddr,
  output logic [ADDR_W-1:0] m9_waddr,
  output logic              m9_we,
  output logic [23:0]       m9_wdata,
  input  logic [23:0]       m9_rdata,
  output logic              sd_write,
  output logic [15:0]       sd_wdata,
  output logic [31:0]       sd_address,
  input  logic              sd_wait,
  output logic              flush_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_pend;
  logic [31:0]       r_base;
  logic              w_start;
  logic              w_accept;
  logic              w_idle;
  // Read data is returned by the M9 itself; the request strobe carries no extra meaning here.
  logic              w_unused_read;

  assign w_unused_read = blend_read;
  assign w_idle        = (r_state == S_IDLE);
  assign w_start       = w_idle && (frame_ready || r_pend);
  assign w_accept      = (r_state == S_WR) && !sd_wait;

  always_comb begin
    blend_rdata = m9_rdata;
    blend_stall = !w_idle;
    m9_raddr    = w_idle ? blend_addr : r_cnt;
    m9_waddr    = blend_addr;
    m9_we       = w_idle && blend_write;
    m9_wdata    = blend_wdata;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_RD;
      S_RD:   w_next = S_RDW;
      S_RDW:  w_next = S_WR;
      S_WR:   if (w_accept) w_next = (r_cnt == LAST) ? S_DONE : S_RD;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_base     <= '0;
      sd_write   <= 1'b0;
      sd_wdata   <= '0;
      sd_address <= '0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      // A request arriving mid-flush is remembered once; extra pulses collapse into it.
      if (w_start)
        r_pend <= 1'b0;
      else if (frame_ready)
        r_pend <= 1'b1;
      if (w_start) begin
        r_base <= frame_base;
        r_cnt  <= '0;
      end
      if (r_state == S_RDW) begin
        sd_wdata   <= {m9_rdata[23:19], m9_rdata[15:10], m9_rdata[7:3]};
        sd_address <= r_base + 32'({r_cnt, 1'b0});
        sd_write   <= 1'b1;
      end
      if (w_accept) begin
        sd_write <= 1'b0;
        if (r_cnt == LAST) flush_done <= 1'b1;
        else               r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m9_flush_scheduler.sv
// Directed bench for m9_flush_scheduler: behavioural M9 RAM, SD_RAM write monitor
// with programmable waitrequest, table of RGB888->RGB565 vectors, flush corner cases.
module tb_m9_flush_scheduler;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        blend_read, blend_write;
  logic [6:0]  blend_addr;
  logic [23:0] blend_wdata, blend_rdata;
  logic        blend_stall;
  logic        frame_ready;
  logic [31:0] frame_base;
  logic [6:0]  m9_raddr, m9_waddr;
  logic        m9_we;
  logic [23:0] m9_wdata, m9_rdata;
  logic        sd_write;
  logic [15:0] sd_wdata;
  logic [31:0] sd_address;
  logic        sd_wait = 1'b0;
  logic        flush_done;

  always #5 clk = ~clk;

  m9_flush_scheduler #(.ADDR_W(7), .DEPTH(128)) dut (
    .clk(clk), .n_rst(n_rst),
    .blend_read(blend_read), .blend_write(blend_write), .blend_addr(blend_addr),
    .blend_wdata(blend_wdata), .blend_rdata(blend_rdata), .blend_stall(blend_stall),
    .frame_ready(frame_ready), .frame_base(frame_base),
    .m9_raddr(m9_raddr), .m9_waddr(m9_waddr), .m9_we(m9_we), .m9_wdata(m9_wdata),
    .m9_rdata(m9_rdata),
    .sd_write(sd_write), .sd_wdata(sd_wdata), .sd_address(sd_address), .sd_wait(sd_wait),
    .flush_done(flush_done)
  );

  // M9 block RAM: registered read, one cycle latency
  logic [23:0] mem [0:127];
  always @(posedge clk) begin
    if (m9_we) mem[m9_waddr] <= m9_wdata;
    m9_rdata <= mem[m9_raddr];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] pat(input int i);
    return {8'(i * 3 + 17), 8'(i * 7), 8'(250 - i)};
  endfunction

  function automatic logic [15:0] to565(input logic [23:0] p);
    return {p[23:19], p[15:10], p[7:3]};
  endfunction

  typedef struct {
    logic [23:0] pix;
    logic [15:0] exp565;
  } vec_t;
  vec_t tbl [9];

  // SD_RAM side: records accepted writes, counts flush_done, injects waitrequest
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic [15:0] got_d [0:1023];
  logic [31:0] got_a [0:1023];
  logic        wait_arm = 1'b0;
  logic        wait_started = 1'b0;
  int          wait_left = 0;
  logic [31:0] wait_addr = '0;
  logic [31:0] snap_a;
  logic [15:0] snap_d;

  always @(negedge clk) begin
    if (flush_done) done_cnt++;
    if (wait_arm && !wait_started && sd_write && sd_address == wait_addr) begin
      sd_wait      = 1'b1;
      wait_started = 1'b1;
      wait_left    = 4;
      snap_a       = sd_address;
      snap_d       = sd_wdata;
    end else if (wait_started && sd_wait) begin
      chk("hold_write", 32'(sd_write), 32'd1);
      chk("hold_addr", sd_address, snap_a);
      chk("hold_data", 32'(sd_wdata), 32'(snap_d));
      if (wait_left > 0) wait_left--;
      else               sd_wait = 1'b0;
    end
    if (sd_write && !sd_wait && wr_cnt < 1024) begin
      got_d[wr_cnt] = sd_wdata;
      got_a[wr_cnt] = sd_address;
      wr_cnt++;
    end
  end

  task automatic drive_wr(input logic [6:0] a, input logic [23:0] d);
    blend_write = 1'b1;
    blend_addr  = a;
    blend_wdata = d;
    @(posedge clk); #1;
    blend_write = 1'b0;
  endtask

  task automatic pulse_frame(input logic [31:0] base);
    frame_base  = base;
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  // One full flush; returns checks of latency, write count, every pixel and address
  task automatic run_flush(input logic [31:0] base, input int exp_cycles, input int poke);
    int start;
    int cyc;
    start = wr_cnt;
    pulse_frame(base);
    cyc = 1;
    while (!flush_done && cyc < 3000) begin
      if (cyc == poke) begin
        blend_write = 1'b1;
        blend_addr  = 7'd5;
        blend_wdata = 24'hAAAAAA;
        #1;
        chk("stall_during_flush", 32'(blend_stall), 32'd1);
        chk("we_blocked", 32'(m9_we), 32'd0);
      end else begin
        blend_write = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    blend_write = 1'b0;
    chk("flush_latency", 32'(cyc), 32'(exp_cycles));
    chk("flush_writes", 32'(wr_cnt - start), 32'd128);
    for (int i = 0; i < 128; i++) begin
      chk("pix_data", 32'(got_d[start + i]), 32'(i < 9 ? tbl[i].exp565 : to565(pat(i))));
      chk("pix_addr", got_a[start + i], base + 32'(2 * i));
    end
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(flush_done), 32'd0);
    chk("idle_after_done", 32'(blend_stall), 32'd0);
  endtask

  initial begin
    int start, d0, cyc, t1, t2, nd;

    tbl[0] = '{24'hFF8040, 16'hFC08};
    tbl[1] = '{24'h000000, 16'h0000};
    tbl[2] = '{24'hFFFFFF, 16'hFFFF};
    tbl[3] = '{24'h080410, 16'h0822};
    tbl[4] = '{24'h070307, 16'h0000};
    tbl[5] = '{24'h123456, 16'h11AA};
    tbl[6] = '{24'hF80000, 16'hF800};
    tbl[7] = '{24'h00FC00, 16'h07E0};
    tbl[8] = '{24'h0000F8, 16'h001F};

    n_rst = 1'b0; blend_read = 1'b0; blend_write = 1'b0; blend_addr = '0;
    blend_wdata = '0; frame_ready = 1'b0; frame_base = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sd_write", 32'(sd_write), 32'd0);
    chk("rst_sd_wdata", 32'(sd_wdata), 32'd0);
    chk("rst_sd_address", sd_address, 32'd0);
    chk("rst_flush_done", 32'(flush_done), 32'd0);
    chk("rst_stall", 32'(blend_stall), 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Idle pass-through: write then read back
    blend_write = 1'b1; blend_addr = 7'd5; blend_wdata = 24'h123456;
    #1;
    chk("idle_we", 32'(m9_we), 32'd1);
    chk("idle_waddr", 32'(m9_waddr), 32'd5);
    chk("idle_wdata", 32'(m9_wdata), 32'h123456);
    chk("idle_stall", 32'(blend_stall), 32'd0);
    @(posedge clk); #1;
    blend_write = 1'b0; blend_read = 1'b1;
    #1;
    chk("idle_raddr", 32'(m9_raddr), 32'd5);
    @(posedge clk); #1;
    chk("idle_rdata", 32'(blend_rdata), 32'h123456);
    blend_read = 1'b0;

    for (int i = 0; i < 128; i++)
      drive_wr(7'(i), i < 9 ? tbl[i].pix : pat(i));

    // Plain flush with a blender write poked in mid-flush
    run_flush(32'h0000_1000, 385, 50);
    blend_read = 1'b1; blend_addr = 7'd5;
    @(posedge clk); #1;
    chk("buffer_unchanged", 32'(blend_rdata), 32'h123456);
    blend_read = 1'b0;

    // Waitrequest held 5 cycles on pixel 3; base chosen so addresses wrap past 2**32
    wait_arm = 1'b1; wait_started = 1'b0; wait_addr = 32'hFFFF_FFC6;
    run_flush(32'hFFFF_FFC0, 390, -1);
    wait_arm = 1'b0;
    chk("wait_seen", 32'(wait_started), 32'd1);

    // Two more frame_ready pulses mid-flush collapse into one extra flush
    start = wr_cnt; t1 = 0; t2 = 0; nd = 0;
    pulse_frame(32'h0000_2000);
    for (cyc = 1; cyc <= 900; cyc++) begin
      frame_ready = (cyc == 100 || cyc == 200);
      if (flush_done) begin
        nd++;
        if (nd == 1) t1 = cyc;
        if (nd == 2) t2 = cyc;
      end
      @(posedge clk); #1;
    end
    frame_ready = 1'b0;
    chk("pend_done_count", 32'(nd), 32'd2);
    chk("pend_first_done", 32'(t1), 32'd385);
    chk("pend_second_done", 32'(t2), 32'd771);
    chk("pend_writes", 32'(wr_cnt - start), 32'd256);
    chk("pend_second_first_addr", got_a[start + 128], 32'h0000_2000);
    chk("pend_second_last_addr", got_a[start + 255], 32'h0000_20FE);
    chk("pend_idle_after", 32'(blend_stall), 32'd0);

    // Asynchronous reset at pixel 40 with a pending request queued
    start = wr_cnt; d0 = done_cnt;
    pulse_frame(32'h0000_4000);
    cyc = 1;
    while ((wr_cnt - start) < 40 && cyc < 1000) begin
      frame_ready = (cyc == 10);
      @(posedge clk); #1;
      cyc++;
    end
    frame_ready = 1'b0;
    chk("abort_reached_pixel40", 32'(wr_cnt - start), 32'd40);
    n_rst = 1'b0;
    #1;
    chk("abort_sd_write", 32'(sd_write), 32'd0);
    chk("abort_sd_address", sd_address, 32'd0);
    chk("abort_sd_wdata", 32'(sd_wdata), 32'd0);
    chk("abort_flush_done", 32'(flush_done), 32'd0);
    chk("abort_stall", 32'(blend_stall), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    chk("abort_no_more_writes", 32'(wr_cnt - start), 32'd40);
    chk("abort_idle", 32'(blend_stall), 32'd0);
    drive_wr(7'd9, 24'h5A5A5A);
    blend_read = 1'b1; blend_addr = 7'd9;
    @(posedge clk); #1;
    chk("post_reset_rdata", 32'(blend_rdata), 32'h5A5A5A);
    blend_read = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
